// File: rtl/binary_cell_pkg.sv
// Shared definitions for the binary cell loader.
// Contents:
//   state_t        - loader FSM state encoding (IDLE, SHIFT, PARITY, LOAD)
//   DEFAULT_WIDTH  - default number of bits assembled / cells driven
// PARITY is only reachable when BINARY_CELL_LOADER_PARITY_EN is defined.
package binary_cell_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2,
      LOAD   = 2'd3
   } state_t;

   localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/binary_cell_loader_bit_counter.sv
// bit_counter: counts accepted serial bits for the loader.
// Ports:
//   clk, rst_n - shared clock and synchronous active-low reset
//   clr        - synchronous clear to 0 (takes priority over en)
//   en         - increment by one
//   count      - current count
//   tc         - terminal-count flag, high while count == WIDTH-1
module bit_counter
   import binary_cell_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] count,
   output logic             tc
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + CNT_W'(1);
      end
   end

   assign tc = (count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/binary_cell_loader.sv
// binary_cell_loader: serial-to-parallel loader feeding a WIDTH-bit array of
// binary cells. Bits arrive LSB-first; once WIDTH bits are assembled the word
// is presented on cell_d together with a one-cycle cell_load strobe.
// Ports:
//   clk, rst_n - rising-edge clock, synchronous active-low reset
//   start      - begin a word (sampled only in IDLE)
//   s_valid    - serial bit valid
//   s_data     - serial bit, LSB first
//   s_ready    - loader can accept a bit
//   cell_d     - parallel word to the cells' d inputs (held between loads)
//   cell_load  - one-cycle load strobe to every cell
//   busy       - high in any state other than IDLE
//   done       - one-cycle pulse coincident with cell_load
//   par_err    - one-cycle parity-failure pulse (0 unless parity enabled)
//   state      - current FSM state, for observation
// Macro BINARY_CELL_LOADER_PARITY_EN: when defined, a trailing even-parity bit
// is accepted after the data bits; a mismatch raises par_err and suppresses
// the load.
//
// Handshake: a serial bit transfers at a rising edge where s_valid and
// s_ready are both high. s_ready is registered and depends only on the state,
// so it never combinationally follows s_valid; the sender may hold s_valid
// low for any number of cycles without losing the partial word.
module binary_cell_loader
   import binary_cell_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             s_valid,
   input  logic             s_data,
   output logic             s_ready,
   output logic [WIDTH-1:0] cell_d,
   output logic             cell_load,
   output logic             busy,
   output logic             done,
   output logic             par_err,
   output state_t           state
);

   state_t           state_next;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] shreg_next;
   logic [WIDTH-1:0] cell_d_next;
   logic             par_err_next;
   logic             cnt_clr;
   logic             cnt_en;
   logic [CNT_W-1:0] count;
   logic             cnt_tc;
   logic             accept;

   assign accept = s_valid && s_ready;

   bit_counter #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_bit_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .count (count),
      .tc    (cnt_tc)
   );

   always_comb begin
      state_next   = state;
      shreg_next   = shreg;
      cell_d_next  = cell_d;
      par_err_next = 1'b0;
      cnt_clr      = 1'b0;
      cnt_en       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = SHIFT;
               cnt_clr    = 1'b1;
            end
         end
         SHIFT: begin
            if (accept) begin
               cnt_en = 1'b1;
               // Write the incoming bit at position count; a loop keeps the
               // index compare at the counter's own width.
               for (int i = 0; i < WIDTH; i++) begin
                  if (count == CNT_W'(i)) begin
                     shreg_next[i] = s_data;
                  end
               end
               if (cnt_tc) begin
`ifdef BINARY_CELL_LOADER_PARITY_EN
                  state_next  = PARITY;
`else
                  state_next  = LOAD;
                  // Capture the word including the bit arriving this edge so
                  // cell_d is valid in the very cycle cell_load is high.
                  cell_d_next = shreg_next;
`endif
               end
            end
         end
         PARITY: begin
`ifdef BINARY_CELL_LOADER_PARITY_EN
            if (accept) begin
               // Even parity: the parity bit equals the XOR of the data bits.
               if (s_data == ^shreg) begin
                  state_next  = LOAD;
                  cell_d_next = shreg;
               end else begin
                  state_next   = IDLE;
                  par_err_next = 1'b1;
               end
            end
`else
            state_next = IDLE;
`endif
         end
         LOAD: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // All outputs are flops computed from the next state, so each output
   // lines up with the state it describes without any input-to-output path.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         shreg     <= '0;
         cell_d    <= '0;
         s_ready   <= 1'b0;
         cell_load <= 1'b0;
         done      <= 1'b0;
         busy      <= 1'b0;
         par_err   <= 1'b0;
      end else begin
         state     <= state_next;
         shreg     <= shreg_next;
         cell_d    <= cell_d_next;
         s_ready   <= (state_next == SHIFT) || (state_next == PARITY);
         cell_load <= (state_next == LOAD);
         done      <= (state_next == LOAD);
         busy      <= (state_next != IDLE);
         par_err   <= par_err_next;
      end
   end

endmodule

// File: tb/tb_binary_cell_loader.sv
// Self-checking bench for binary_cell_loader (WIDTH=8).
// Build with BINARY_CELL_LOADER_PARITY_EN defined to exercise the parity path.
module tb_binary_cell_loader;
   import binary_cell_pkg::*;

   localparam int W = 8;

   logic         clk     = 1'b0;
   logic         rst_n   = 1'b0;
   logic         start   = 1'b0;
   logic         s_valid = 1'b0;
   logic         s_data  = 1'b0;
   logic         s_ready;
   logic [W-1:0] cell_d;
   logic         cell_load;
   logic         busy;
   logic         done;
   logic         par_err;
   state_t       state;

   logic [W-1:0] cells;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] obs_q[$];
   int           tests_run    = 0;
   int           tests_failed = 0;
   int           load_cnt     = 0;
   int           done_cnt     = 0;
   int           perr_cnt     = 0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   binary_cell_loader #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .s_valid   (s_valid),
      .s_data    (s_data),
      .s_ready   (s_ready),
      .cell_d    (cell_d),
      .cell_load (cell_load),
      .busy      (busy),
      .done      (done),
      .par_err   (par_err),
      .state     (state)
   );

   // Downstream cell array: each cell captures d when load is high.
   always @(posedge clk) begin
      if (!rst_n) cells <= '0;
      else if (cell_load) cells <= cell_d;
   end

   // Pulse monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (cell_load) begin
         load_cnt++;
         obs_q.push_back(cell_d);
      end
      if (done) done_cnt++;
      if (par_err) perr_cnt++;
   end

   // ---------------- reference model ----------------
   function automatic logic [W-1:0] model_word(input logic bits[W]);
      int v = 0;
      for (int k = 0; k < W; k++) v = v + (bits[k] ? (1 << k) : 0);
      return W'(v);
   endfunction

   function automatic logic model_parity(input logic bits[W]);
      int ones = 0;
      for (int k = 0; k < W; k++) ones = ones + int'(bits[k]);
      return logic'(ones % 2);
   endfunction

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic drive_bit(input logic b, output bit timeout);
      int guard = 0;
      timeout = 0;
      s_valid = 1'b1;
      s_data  = b;
      while (s_ready !== 1'b1 && guard < 50) begin
         step();
         guard++;
      end
      if (guard >= 50) timeout = 1;
      step();
      s_valid = 1'b0;
   endtask

   // Sends WIDTH bits (plus the parity bit when enabled), stalling stall_len
   // cycles after every bit whose stall_mask bit is set. Returns #1 after the
   // last accepting edge, i.e. inside the expected LOAD (or par_err) cycle.
   task automatic send_bits(input logic bits[W], input logic par_flip,
                            input logic [W-1:0] stall_mask, input int stall_len,
                            output int ready_low, output int busy_low,
                            output bit timeout);
      bit to;
      ready_low = 0;
      busy_low  = 0;
      timeout   = 0;
      for (int k = 0; k < W; k++) begin
         drive_bit(bits[k], to);
         if (to) timeout = 1;
         if (k < W - 1) begin
            if (s_ready !== 1'b1) ready_low++;
            if (busy !== 1'b1) busy_low++;
            if (stall_mask[k]) begin
               for (int j = 0; j < stall_len; j++) begin
                  step();
                  if (s_ready !== 1'b1) ready_low++;
                  if (busy !== 1'b1) busy_low++;
               end
            end
         end
      end
`ifdef BINARY_CELL_LOADER_PARITY_EN
      drive_bit(model_parity(bits) ^ par_flip, to);
      if (to) timeout = 1;
`else
      if (par_flip) timeout = timeout;
`endif
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic b[W];
      bit   to;
      rst_n = 1'b0;
      step();
      step();
      tests_run++;
      if ({s_ready, cell_load, done, par_err, busy, cell_d} !== '0 || state !== IDLE) begin
         tests_failed++;
         $display("FAIL reset_init: outs=%b cell_d=%h state=%0d expected all zero, IDLE",
                  {s_ready, cell_load, done, par_err, busy}, cell_d, state);
      end
      rst_n = 1'b1;
      // s_valid in IDLE is ignored
      s_valid = 1'b1;
      s_data  = 1'b1;
      step();
      step();
      s_valid = 1'b0;
      tests_run++;
      if (s_ready !== 1'b0 || state !== IDLE || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL idle_ignores_valid: s_ready=%b state=%0d busy=%b expected 0 IDLE 0",
                  s_ready, state, busy);
      end
      // reset mid-word after 3 accepted bits
      drive_start();
      for (int k = 0; k < 3; k++) drive_bit(1'b1, to);
      rst_n = 1'b0;
      step();
      step();
      tests_run++;
      if ({s_ready, cell_load, done, par_err, busy, cell_d} !== '0 || state !== IDLE) begin
         tests_failed++;
         $display("FAIL reset_mid_word: outs=%b cell_d=%h state=%0d expected all zero, IDLE",
                  {s_ready, cell_load, done, par_err, busy}, cell_d, state);
      end
      rst_n = 1'b1;
      for (int k = 0; k < W; k++) b[k] = 1'b1;
      s_valid = 1'b1;
      for (int k = 0; k < 12; k++) begin
         s_data = 1'(k);
         step();
      end
      s_valid = 1'b0;
      tests_run++;
      if (load_cnt !== 0 || done_cnt !== 0 || state !== IDLE) begin
         tests_failed++;
         $display("FAIL reset_no_load: loads=%0d dones=%0d state=%0d expected 0 0 IDLE",
                  load_cnt, done_cnt, state);
      end
   endtask

   task automatic test_basic();
      logic         b[W] = '{1, 0, 1, 1, 0, 0, 1, 0};
      logic [W-1:0] obs;
      int           rl, bl, lc0;
      bit           to;
      lc0 = load_cnt;
      exp_q.push_back(model_word(b));
      drive_start();
      tests_run++;
      if (busy !== 1'b1 || s_ready !== 1'b1 || state !== SHIFT) begin
         tests_failed++;
         $display("FAIL basic_after_start: busy=%b s_ready=%b state=%0d expected 1 1 SHIFT",
                  busy, s_ready, state);
      end
      send_bits(b, 1'b0, '0, 0, rl, bl, to);
      tests_run++;
      if (to || cell_load !== 1'b1 || done !== 1'b1 || cell_d !== 8'h4D || s_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL basic_load: timeout=%0d cell_load=%b done=%b cell_d=%h s_ready=%b expected 0 1 1 4d 0",
                  to, cell_load, done, cell_d, s_ready);
      end
      step();
      tests_run++;
      if (cell_load !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || cell_d !== 8'h4D || cells !== 8'h4D) begin
         tests_failed++;
         $display("FAIL basic_after_load: cell_load=%b done=%b busy=%b cell_d=%h cells=%h expected 0 0 0 4d 4d",
                  cell_load, done, busy, cell_d, cells);
      end
      obs = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      tests_run++;
      if (load_cnt - lc0 !== 1 || obs !== exp_q.pop_front()) begin
         tests_failed++;
         $display("FAIL basic_scoreboard: loads=%0d word=%h expected 1 4d", load_cnt - lc0, obs);
      end
   endtask

   task automatic test_stalls();
      logic b[W] = '{1, 0, 1, 1, 0, 0, 1, 0};
      int   rl, bl;
      bit   to;
      step();
      drive_start();
      send_bits(b, 1'b0, 8'b0001_0010, 3, rl, bl, to);
      tests_run++;
      if (to || cell_load !== 1'b1 || cell_d !== model_word(b)) begin
         tests_failed++;
         $display("FAIL stall_word: timeout=%0d cell_load=%b cell_d=%h expected 0 1 %h",
                  to, cell_load, cell_d, model_word(b));
      end
      tests_run++;
      if (rl !== 0 || bl !== 0) begin
         tests_failed++;
         $display("FAIL stall_ready: ready_low=%0d busy_low=%0d expected 0 0", rl, bl);
      end
      step();
      void'(obs_q.pop_front());
   endtask

   task automatic test_start_ignored();
      logic b[W];
      int   rl, bl, lc0;
      bit   to;
      for (int k = 0; k < W; k++) b[k] = 1'($urandom_range(0, 1));
      lc0 = load_cnt;
      step();
      drive_start();
      start = 1'b1;   // held through SHIFT and LOAD
      send_bits(b, 1'b0, 8'b0000_1000, 2, rl, bl, to);
      tests_run++;
      if (to || cell_load !== 1'b1 || cell_d !== model_word(b) || bl !== 0) begin
         tests_failed++;
         $display("FAIL start_in_shift: timeout=%0d cell_load=%b cell_d=%h busy_low=%0d expected 0 1 %h 0",
                  to, cell_load, cell_d, bl, model_word(b));
      end
      step();
      start = 1'b0;
      tests_run++;
      if (state !== IDLE || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL start_in_load: state=%0d busy=%b expected IDLE 0", state, busy);
      end
      step();
      step();
      tests_run++;
      if (load_cnt - lc0 !== 1 || state !== IDLE) begin
         tests_failed++;
         $display("FAIL start_one_load: loads=%0d state=%0d expected 1 IDLE", load_cnt - lc0, state);
      end
      obs_q.delete();
   endtask

   task automatic test_back_to_back();
      logic b1[W];
      logic b2[W];
      int   rl, bl, lc0;
      bit   to;
      for (int k = 0; k < W; k++) begin
         b1[k] = 1'b1;
         b2[k] = 1'b0;
      end
      lc0 = load_cnt;
      drive_start();
      send_bits(b1, 1'b0, '0, 0, rl, bl, to);
      step();
      tests_run++;
      if (state !== IDLE || cell_d !== model_word(b1)) begin
         tests_failed++;
         $display("FAIL b2b_gap: state=%0d cell_d=%h expected IDLE ff", state, cell_d);
      end
      drive_start();
      tests_run++;
      if (state !== SHIFT || cell_d !== model_word(b1)) begin
         tests_failed++;
         $display("FAIL b2b_hold: state=%0d cell_d=%h expected SHIFT ff", state, cell_d);
      end
      send_bits(b2, 1'b0, '0, 0, rl, bl, to);
      tests_run++;
      if (to || cell_load !== 1'b1 || cell_d !== model_word(b2) || load_cnt - lc0 !== 1) begin
         tests_failed++;
         $display("FAIL b2b_second: timeout=%0d cell_load=%b cell_d=%h loads=%0d expected 0 1 00 1",
                  to, cell_load, cell_d, load_cnt - lc0);
      end
      step();
      tests_run++;
      if (load_cnt - lc0 !== 2 || cells !== model_word(b2)) begin
         tests_failed++;
         $display("FAIL b2b_count: loads=%0d cells=%h expected 2 00", load_cnt - lc0, cells);
      end
      obs_q.delete();
   endtask

   task automatic test_random();
      logic         b[W];
      logic [W-1:0] obs;
      int           rl, bl;
      bit           to;
      for (int n = 0; n < 12; n++) begin
         for (int k = 0; k < W; k++) b[k] = 1'($urandom_range(0, 1));
         exp_q.push_back(model_word(b));
         repeat ($urandom_range(0, 2)) step();
         drive_start();
         send_bits(b, 1'b0, W'($urandom), $urandom_range(0, 3), rl, bl, to);
         step();
         obs = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
         tests_run++;
         if (to || obs !== exp_q[0] || cells !== exp_q[0] || rl !== 0 || obs_q.size() !== 0) begin
            tests_failed++;
            $display("FAIL random_word %0d: timeout=%0d loaded=%h cells=%h ready_low=%0d expected %h",
                     n, to, obs, cells, rl, exp_q[0]);
         end
         void'(exp_q.pop_front());
      end
   endtask

`ifdef BINARY_CELL_LOADER_PARITY_EN
   task automatic test_parity();
      logic b[W] = '{1, 0, 1, 1, 0, 0, 1, 0};
      int   rl, bl, lc0, pe0;
      bit   to;
      step();
      drive_start();
      send_bits(b, 1'b0, '0, 0, rl, bl, to);
      tests_run++;
      if (to || cell_load !== 1'b1 || par_err !== 1'b0 || cell_d !== 8'h4D) begin
         tests_failed++;
         $display("FAIL parity_good: timeout=%0d cell_load=%b par_err=%b cell_d=%h expected 0 1 0 4d",
                  to, cell_load, par_err, cell_d);
      end
      step();
      lc0 = load_cnt;
      pe0 = perr_cnt;
      drive_start();
      send_bits(b, 1'b1, '0, 0, rl, bl, to);
      tests_run++;
      if (to || par_err !== 1'b1 || cell_load !== 1'b0 || done !== 1'b0 || cell_d !== 8'h4D) begin
         tests_failed++;
         $display("FAIL parity_bad: timeout=%0d par_err=%b cell_load=%b done=%b cell_d=%h expected 0 1 0 0 4d",
                  to, par_err, cell_load, done, cell_d);
      end
      step();
      tests_run++;
      if (par_err !== 1'b0 || state !== IDLE || load_cnt !== lc0 || perr_cnt - pe0 !== 1) begin
         tests_failed++;
         $display("FAIL parity_after: par_err=%b state=%0d new_loads=%0d perr=%0d expected 0 IDLE 0 1",
                  par_err, state, load_cnt - lc0, perr_cnt - pe0);
      end
      obs_q.delete();
   endtask
`else
   task automatic test_parity_off();
      tests_run++;
      if (perr_cnt !== 0 || par_err !== 1'b0) begin
         tests_failed++;
         $display("FAIL par_err_tied: pulses=%0d par_err=%b expected 0 0", perr_cnt, par_err);
      end
   endtask
`endif

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_basic();
      test_stalls();
      test_start_ignored();
      test_back_to_back();
      test_random();
`ifdef BINARY_CELL_LOADER_PARITY_EN
      test_parity();
`else
      test_parity_off();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/binary_cell_loader.md
Name: binary_cell_loader

Overview:
Serial-to-parallel loader that feeds a WIDTH-bit word register built from binary cells.
- Accepts a bit stream on a valid/ready handshake and assembles WIDTH bits LSB-first.
- Drives the cells' shared load strobe and per-bit data for one cycle once the word is complete.
- Sits directly upstream of the cell array; cell_d[i] feeds cell i's d input, and cell_load feeds every cell's load input.

Parameters:
WIDTH, 8, number of bits assembled and number of downstream cells driven (>=2)
CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not overridden

Ports:
clk  in  1  rising-edge clock, shared with the cell array
rst_n  in  1  synchronous active-low reset
start  in  1  begin a word; sampled only in IDLE
s_valid  in  1  serial bit valid
s_data  in  1  serial bit, LSB first
s_ready  out  1  loader can accept a bit
cell_d  out  WIDTH  parallel word to the cells' d inputs
cell_load  out  1  one-cycle load strobe to the cells' load inputs
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse, coincident with cell_load
par_err  out  1  one-cycle parity-failure pulse; constant 0 unless PARITY_EN

Behaviour:
- Reset: rst_n low at a rising clk edge sets the following:
  - state=IDLE, shift register=0, count=0
  - s_ready=0, cell_load=0, done=0, par_err=0, busy=0, cell_d=0
- Reset mid-word aborts the word; no cell_load is issued.
- States: IDLE, SHIFT, (PARITY), LOAD.
- IDLE:
  - s_ready=0.
  - start=1 -> SHIFT, count<=0.
  - s_valid is ignored.
- SHIFT:
  - s_ready=1 (registered).
  - A bit is accepted only when s_valid&&s_ready at a clock edge.
  - Bit number k (k=0..WIDTH-1) is written to shreg[k].
  - On the accept where count==WIDTH-1 -> LOAD (or PARITY when enabled); s_ready drops in the next cycle.
  - Cycles with s_valid=0 hold state; there is no timeout.
- LOAD:
  - Lasts exactly 1 cycle: cell_load=1, done=1, then -> IDLE.
  - cell_d equals the assembled word during LOAD and holds that value afterwards until the next LOAD (register-driven, never glitching).
- Latency: last bit accepted at edge N -> cell_load high between edges N and N+1 -> cells capture at edge N+1.
- start while busy is ignored.
- start in the LOAD cycle is ignored; a new start is honoured from IDLE on the next cycle.
- Back-to-back words: minimum gap is 1 IDLE cycle.
- cell_d is not cleared on a new start; it updates only at LOAD.
- Outputs are all registered; there are no combinational paths from inputs to outputs.

Optional Feature:
Macro: BINARY_CELL_LOADER_PARITY_EN
- Defined:
  - After WIDTH data bits, state PARITY accepts one more serial bit (s_ready=1) as even parity over the data bits.
  - Match -> LOAD as normal.
  - Mismatch -> par_err=1 for one cycle, no cell_load, no done; cell_d keeps its old value; -> IDLE.
- Undefined: the PARITY state is absent, and par_err is tied 0.

Decomposition:
- Shared package binary_cell_pkg:
  - state encoding constants IDLE=2'd0, SHIFT=2'd1, PARITY=2'd2, LOAD=2'd3
  - default WIDTH constant
- One natural sub-module: bit_counter.
  - Synchronous clear and enable.
  - Terminal-count flag at WIDTH-1.
  - Same clk and rst_n.

Test Plan:
- Reset: hold rst_n=0 for 2 edges mid-SHIFT after 3 bits accepted -> all outputs 0, state IDLE, no cell_load ever seen.
- Basic load, WIDTH=8: start, then bits 1,0,1,1,0,0,1,0 LSB-first with s_valid continuous -> cell_load and done high for exactly 1 cycle, 1 cycle after the 8th accept; cell_d=8'h4D; downstream cells read 8'h4D.
- Stalls: same word with s_valid deasserted for 3 cycles after bits 2 and 5 -> identical cell_d=8'h4D; s_ready stays 1 throughout SHIFT.
- start during SHIFT and during LOAD -> ignored; exactly one cell_load per word; busy high from the cycle after start to the end of LOAD.
- Back-to-back: words 8'hFF then 8'h00 with start asserted in the first IDLE cycle after LOAD -> two cell_load pulses; cell_d holds 8'hFF until the second LOAD.
- PARITY_EN defined:
  - word 8'h4D with parity 0 -> load 8'h4D.
  - word 8'h4D with parity 1 -> par_err pulse, no cell_load, cell_d unchanged.
